// File: rtl/load_use_stall_if.sv
// Hazard-unit bundle: ID/EX/MEM hazard sources in, stall/flush/freeze out.
// stall_cycles exists only when LOAD_USE_STALL_PERF_EN is defined.
interface load_use_stall_if #(
  parameter int CNT_W = 16
);
  logic [4:0] rs1id;
  logic [4:0] rs2id;
  logic [1:0] float_read;
  logic [4:0] rdex;
  logic       wbex;
  logic       memrex;
  logic       fw_iex;
  logic       memr_mem;
  logic       mem_ack;
  logic       stall_pc;
  logic       stall_ifid;
  logic       flush_idex;
  logic       freeze;
  logic       mem_err;
`ifdef LOAD_USE_STALL_PERF_EN
  logic [CNT_W-1:0] stall_cycles;
`endif

  modport master (
    output rs1id, rs2id, float_read,
    output rdex, wbex, memrex, fw_iex,
    output memr_mem, mem_ack,
    input  stall_pc, stall_ifid,
    input  flush_idex, freeze, mem_err
`ifdef LOAD_USE_STALL_PERF_EN
    , input stall_cycles
`endif
  );

  modport slave (
    input  rs1id, rs2id, float_read,
    input  rdex, wbex, memrex, fw_iex,
    input  memr_mem, mem_ack,
    output stall_pc, stall_ifid,
    output flush_idex, freeze, mem_err
`ifdef LOAD_USE_STALL_PERF_EN
    , output stall_cycles
`endif
  );
endinterface

// File: rtl/load_use_stall.sv
// Load-use bubble insertion and bounded MEM-load freeze with timeout abort.
// Optional stall counter: define LOAD_USE_STALL_PERF_EN.
module load_use_stall #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input logic            clk,
  input logic            rst_n,
  load_use_stall_if.slave bus
);

  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] TO_V = WC_W'(TIMEOUT);

  typedef enum logic [1:0] {
    RUN, MWAIT, ERR
  } state_e;

  state_e          state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;

  logic lu_hit;
  logic mwait;
  logic stall_pc, stall_ifid;
  logic flush_idex, freeze, mem_err;

  always_comb begin
    lu_hit = bus.memrex & bus.wbex
           & (bus.rdex != 5'd0)
           & (((bus.rdex == bus.rs1id)
               & (bus.float_read[1] == bus.fw_iex))
            | ((bus.rdex == bus.rs2id)
               & (bus.float_read[0] == bus.fw_iex)));
    mwait = bus.memr_mem & ~bus.mem_ack;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    stall_pc   = 1'b0;
    stall_ifid = 1'b0;
    flush_idex = 1'b0;
    freeze     = 1'b0;
    mem_err    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mwait) begin
          freeze     = 1'b1;
          state_d    = MWAIT;
          wait_cnt_d = WC_W'(1);
        end else if (lu_hit) begin
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
          flush_idex = 1'b1;
        end
      end
      MWAIT: begin
        if (bus.mem_ack) begin
          // released this cycle, so a pending load-use still needs its bubble
          stall_pc   = lu_hit;
          stall_ifid = lu_hit;
          flush_idex = lu_hit;
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == TO_V) begin
          freeze  = 1'b1;
          state_d = ERR;
        end else begin
          freeze     = 1'b1;
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      ERR: begin
        mem_err    = 1'b1;
        flush_idex = 1'b1;
        state_d    = RUN;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign bus.stall_pc   = rst_n & stall_pc;
  assign bus.stall_ifid = rst_n & stall_ifid;
  assign bus.flush_idex = rst_n & flush_idex;
  assign bus.freeze     = rst_n & freeze;
  assign bus.mem_err    = rst_n & mem_err;

`ifdef LOAD_USE_STALL_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if ((stall_pc | freeze) && !(&stall_cycles_q))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  assign bus.stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_load_use_stall.sv
// Directed checks for load_use_stall with TIMEOUT=4.
// Output vector order: {stall_pc,stall_ifid,flush_idex,freeze,mem_err}.
module tb_load_use_stall;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  load_use_stall_if #(.CNT_W(16)) bus ();

  load_use_stall #(
    .TIMEOUT(4),
    .CNT_W  (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  logic [4:0] outs;
  assign outs = {bus.stall_pc, bus.stall_ifid,
                 bus.flush_idex, bus.freeze, bus.mem_err};

  localparam logic [4:0] O_NONE = 5'b00000;
  localparam logic [4:0] O_LU   = 5'b11100;
  localparam logic [4:0] O_FRZ  = 5'b00010;
  localparam logic [4:0] O_ERR  = 5'b00101;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // inputs were set just after a posedge; check mid-cycle, advance
  task automatic cyc(input string tag, input logic [4:0] exp);
    #3;
    chk(tag, {27'd0, outs}, {27'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.rs1id      = 5'd0;
    bus.rs2id      = 5'd0;
    bus.float_read = 2'b00;
    bus.rdex       = 5'd0;
    bus.wbex       = 1'b0;
    bus.memrex     = 1'b0;
    bus.fw_iex     = 1'b0;
    bus.memr_mem   = 1'b0;
    bus.mem_ack    = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd,
                        input logic [4:0] r1,
                        input logic [4:0] r2,
                        input logic [1:0] fr,
                        input logic       fw);
    bus.rdex       = rd;
    bus.rs1id      = r1;
    bus.rs2id      = r2;
    bus.float_read = fr;
    bus.fw_iex     = fw;
    bus.memrex     = 1'b1;
    bus.wbex       = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    @(posedge clk);
    #1;
    set_lu(5'd5, 5'd5, 5'd0, 2'b00, 1'b0);
    cyc("reset_gate", O_NONE);
    clr();
    cyc("reset_idle", O_NONE);
    rst_n = 1'b1;
    cyc("idle", O_NONE);

    // load-use hazards
    set_lu(5'd5, 5'd5, 5'd0, 2'b00, 1'b0);
    cyc("lu_rs1", O_LU);
    clr();
    cyc("lu_bubble", O_NONE);
    set_lu(5'd7, 5'd1, 5'd7, 2'b00, 1'b0);
    cyc("lu_rs2", O_LU);
    set_lu(5'd0, 5'd0, 5'd0, 2'b00, 1'b0);
    cyc("lu_x0", O_NONE);
    set_lu(5'd5, 5'd5, 5'd0, 2'b10, 1'b0);
    cyc("lu_fp_vs_int", O_NONE);
    set_lu(5'd5, 5'd5, 5'd0, 2'b10, 1'b1);
    cyc("lu_fp_fp", O_LU);
    set_lu(5'd9, 5'd9, 5'd9, 2'b00, 1'b0);
    bus.wbex = 1'b0;
    cyc("lu_no_wb", O_NONE);
    clr();
    bus.mem_ack = 1'b1;
    cyc("stray_ack", O_NONE);

    // memory wait released by ack
    clr();
    bus.memr_mem = 1'b1;
    for (int i = 0; i < 3; i++) cyc("mwait_frz", O_FRZ);
    bus.mem_ack = 1'b1;
    cyc("mwait_ack", O_NONE);
    clr();
    cyc("mwait_run", O_NONE);

    // timeout: 5 freeze cycles then one ERR cycle
    bus.memr_mem = 1'b1;
    for (int i = 0; i < 5; i++) cyc("to_frz", O_FRZ);
    bus.memr_mem = 1'b0;
    cyc("to_err", O_ERR);
    cyc("to_run", O_NONE);

    // lu_hit together with memory wait
    set_lu(5'd3, 5'd3, 5'd0, 2'b00, 1'b0);
    bus.memr_mem = 1'b1;
    cyc("both_frz0", O_FRZ);
    cyc("both_frz1", O_FRZ);
    bus.mem_ack = 1'b1;
    cyc("both_ack_lu", O_LU);
    clr();
    cyc("both_bubble", O_NONE);

    // reset in the middle of a wait
    bus.memr_mem = 1'b1;
    cyc("rst_frz0", O_FRZ);
    cyc("rst_frz1", O_FRZ);
    rst_n = 1'b0;
    cyc("rst_mid", O_NONE);
    cyc("rst_hold", O_NONE);
    rst_n = 1'b1;
    clr();
`ifdef LOAD_USE_STALL_PERF_EN
    #1;
    chk("perf_rst", {16'd0, bus.stall_cycles}, 32'd0);
`endif
    cyc("rst_no_err", O_NONE);
    bus.memr_mem = 1'b1;
    cyc("rst_frz_again", O_FRZ);
    bus.mem_ack = 1'b1;
`ifdef LOAD_USE_STALL_PERF_EN
    #1;
    chk("perf_one", {16'd0, bus.stall_cycles}, 32'd1);
`endif
    cyc("rst_ack_again", O_NONE);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no_finish expected finish");
    $fatal(1);
  end

endmodule
